// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bundle: instruction RAM port, redirect request and the decode handshake.
// The master modport is the fetch controller, the slave modport is the RAM/core side.
interface ifetch_ctrl_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic [PC_WIDTH-1:0]    mem_pc;
    logic                   mem_pc_vld;
    logic [INSTR_WIDTH-1:0] mem_instr;
    logic                   redirect_vld;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   out_vld;
    logic                   out_rdy;
    logic [PC_WIDTH-1:0]    out_pc;
    logic [INSTR_WIDTH-1:0] out_instr;

    modport master (
        output mem_pc, mem_pc_vld, out_vld, out_pc, out_instr,
        input  mem_instr, redirect_vld, redirect_pc, out_rdy
    );

    modport slave (
        input  mem_pc, mem_pc_vld, out_vld, out_pc, out_instr,
        output mem_instr, redirect_vld, redirect_pc, out_rdy
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: issues word-aligned PCs to a 1-cycle RAM, buffers
// returned words in a 2-entry FIFO and hands {pc, instr} to decode.
module ifetch_ctrl #(
    parameter int                    PC_WIDTH    = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_ctrl_if.master bus
);
    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] PC_ALIGN = ~PC_WIDTH'(3);

    logic [PC_WIDTH-1:0] fpc;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic                inflight;
    entry_t              fifo [2];
    logic                head, tail;
    logic [1:0]          count;

    logic [1:0] occ;
    logic       vld, pop, push, issue;

    always_comb begin
        vld   = (count != 2'd0);
        pop   = vld & bus.out_rdy;
        occ   = count + {1'b0, inflight};
        // Refill into the slot freed by this cycle's pop keeps 1 instr/cycle under occ==2.
        issue = !rst && !bus.redirect_vld &&
                ((occ < 2'd2) || ((occ == 2'd2) && pop));
        // A response landing in a redirect cycle belongs to the old path.
        push  = inflight && !bus.redirect_vld;
    end

    assign bus.mem_pc     = fpc;
    assign bus.mem_pc_vld = issue;
    assign bus.out_vld    = vld;
    assign bus.out_pc     = fifo[head].pc;
    assign bus.out_instr  = fifo[head].instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc         <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= 1'b0;
            tail        <= 1'b0;
            count       <= 2'd0;
            fifo[0]     <= '0;
            fifo[1]     <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fpc         <= fpc + PC_STEP;
                inflight_pc <= fpc;
            end
            if (bus.redirect_vld) begin
                fpc   <= bus.redirect_pc & PC_ALIGN;
                head  <= 1'b0;
                tail  <= 1'b0;
                count <= 2'd0;
            end else begin
                if (push) begin
                    fifo[tail] <= '{pc: inflight_pc, instr: bus.mem_instr};
                    tail       <= ~tail;
                end
                if (pop)
                    head <= ~head;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: startup, backpressure, redirects, wrap-around and
// mid-stream reset against a 1-cycle RAM holding word[i] = 0x1000 + i.
module tb_ifetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ifetch_ctrl_if bus ();
    ifetch_ctrl_if wbus ();

    ifetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    ifetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (.clk(clk), .rst(rst), .bus(wbus));

    function automatic logic [31:0] ram_word(input logic [31:0] pc);
        return 32'h1000 + (pc >> 2);
    endfunction

    // Registered-read RAM; output holds when not enabled.
    always @(posedge clk) begin
        if (bus.mem_pc_vld)  bus.mem_instr  <= ram_word(bus.mem_pc);
        if (wbus.mem_pc_vld) wbus.mem_instr <= ram_word(wbus.mem_pc);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%08h exp=%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic out_chk(input string tag, input logic [31:0] pc);
        chk({tag, ".vld"}, 32'(bus.out_vld), 32'd1);
        chk({tag, ".pc"}, bus.out_pc, pc);
        chk({tag, ".instr"}, bus.out_instr, ram_word(pc));
    endtask

    // Leaves the bench 1ns into cycle 0 with inputs settled.
    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        bus.redirect_vld = 1'b0;
        bus.redirect_pc  = '0;
        bus.out_rdy      = rdy;
        tick();
        tick();
        chk("rst.out_vld", 32'(bus.out_vld), 32'd0);
        chk("rst.mem_pc_vld", 32'(bus.mem_pc_vld), 32'd0);
        chk("rst.mem_pc", bus.mem_pc, 32'h0);
        chk("rst.out_pc", bus.out_pc, 32'h0);
        chk("rst.out_instr", bus.out_instr, 32'h0);
        chk("rst.wrap_mem_pc", wbus.mem_pc, 32'hFFFF_FFF8);
        tick();
        rst = 1'b0;
        #1;
    endtask

    logic [31:0] wrap_exp [4];

    initial begin
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;
        wbus.redirect_vld = 1'b0;
        wbus.redirect_pc  = '0;
        wbus.out_rdy      = 1'b1;

        // Startup with free-running decode, wrap instance alongside.
        do_reset(1'b1);
        chk("start.c0.mem_pc_vld", 32'(bus.mem_pc_vld), 32'd1);
        chk("start.c0.mem_pc", bus.mem_pc, 32'h0);
        chk("start.c0.out_vld", 32'(bus.out_vld), 32'd0);
        tick(); #1;
        chk("start.c1.out_vld", 32'(bus.out_vld), 32'd0);
        chk("start.c1.mem_pc", bus.mem_pc, 32'h4);
        for (int k = 0; k < 6; k++) begin
            tick(); #1;
            out_chk($sformatf("start.c%0d", k + 2), 32'(4 * k));
            chk($sformatf("start.c%0d.mem_pc_vld", k + 2), 32'(bus.mem_pc_vld), 32'd1);
            if (k < 4) begin
                chk($sformatf("wrap.%0d.vld", k), 32'(wbus.out_vld), 32'd1);
                chk($sformatf("wrap.%0d.pc", k), wbus.out_pc, wrap_exp[k]);
            end
        end

        // Backpressure from cycle 2 to cycle 6, release in cycle 7.
        do_reset(1'b0);
        tick(); #1;
        chk("bp.c1.out_vld", 32'(bus.out_vld), 32'd0);
        for (int k = 2; k < 7; k++) begin
            tick(); #1;
            chk($sformatf("bp.c%0d.out_vld", k), 32'(bus.out_vld), 32'd1);
            chk($sformatf("bp.c%0d.out_pc", k), bus.out_pc, 32'h0);
            chk($sformatf("bp.c%0d.mem_pc_vld", k), 32'(bus.mem_pc_vld), 32'd0);
        end
        tick();
        bus.out_rdy = 1'b1;
        #1;
        chk("bp.c7.mem_pc_vld", 32'(bus.mem_pc_vld), 32'd1);
        chk("bp.c7.mem_pc", bus.mem_pc, 32'h8);
        out_chk("bp.c7", 32'h0);
        tick(); #1; out_chk("bp.c8", 32'h4);
        tick(); #1; out_chk("bp.c9", 32'h8);
        tick(); #1; out_chk("bp.c10", 32'hC);

        // Redirect to 0x43 while 0x8 is buffered and 0xC is in flight.
        do_reset(1'b1);
        repeat (3) tick();
        tick();
        bus.out_rdy = 1'b0;
        bus.redirect_vld = 1'b1;
        bus.redirect_pc = 32'h43;
        #1;
        chk("rd.t.out_pc", bus.out_pc, 32'h8);
        chk("rd.t.mem_pc_vld", 32'(bus.mem_pc_vld), 32'd0);
        tick();
        bus.redirect_vld = 1'b0;
        bus.out_rdy = 1'b1;
        #1;
        chk("rd.t1.out_vld", 32'(bus.out_vld), 32'd0);
        chk("rd.t1.mem_pc_vld", 32'(bus.mem_pc_vld), 32'd1);
        chk("rd.t1.mem_pc", bus.mem_pc, 32'h40);
        tick(); #1;
        chk("rd.t2.out_vld", 32'(bus.out_vld), 32'd0);
        tick(); #1; out_chk("rd.t3", 32'h40);
        tick(); #1; out_chk("rd.t4", 32'h44);

        // Redirect coinciding with the pop of 0x8, then back-to-back redirects.
        do_reset(1'b1);
        repeat (3) tick();
        tick();
        bus.redirect_vld = 1'b1;
        bus.redirect_pc = 32'h100;
        #1;
        out_chk("rp.t", 32'h8);
        tick();
        bus.redirect_vld = 1'b0;
        #1;
        chk("rp.t1.out_vld", 32'(bus.out_vld), 32'd0);
        chk("rp.t1.mem_pc", bus.mem_pc, 32'h100);
        tick(); #1;
        chk("rp.t2.out_vld", 32'(bus.out_vld), 32'd0);
        tick(); #1;
        out_chk("rp.t3", 32'h100);
        bus.redirect_vld = 1'b1;
        bus.redirect_pc = 32'h203;
        #1;
        chk("b2b.0.mem_pc_vld", 32'(bus.mem_pc_vld), 32'd0);
        tick();
        bus.redirect_pc = 32'h300;
        #1;
        chk("b2b.1.out_vld", 32'(bus.out_vld), 32'd0);
        chk("b2b.1.mem_pc_vld", 32'(bus.mem_pc_vld), 32'd0);
        tick();
        bus.redirect_vld = 1'b0;
        #1;
        chk("b2b.2.out_vld", 32'(bus.out_vld), 32'd0);
        chk("b2b.2.mem_pc_vld", 32'(bus.mem_pc_vld), 32'd1);
        chk("b2b.2.mem_pc", bus.mem_pc, 32'h300);
        tick(); #1;
        chk("b2b.3.out_vld", 32'(bus.out_vld), 32'd0);
        tick(); #1; out_chk("b2b.4", 32'h300);

        // One-cycle reset mid-stream with a read in flight.
        do_reset(1'b1);
        repeat (3) tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mr.rst.mem_pc_vld", 32'(bus.mem_pc_vld), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr.c0.out_vld", 32'(bus.out_vld), 32'd0);
        chk("mr.c0.out_pc", bus.out_pc, 32'h0);
        chk("mr.c0.out_instr", bus.out_instr, 32'h0);
        chk("mr.c0.mem_pc", bus.mem_pc, 32'h0);
        chk("mr.c0.mem_pc_vld", 32'(bus.mem_pc_vld), 32'd1);
        tick(); #1;
        chk("mr.c1.out_vld", 32'(bus.out_vld), 32'd0);
        tick(); #1; out_chk("mr.c2", 32'h0);
        tick(); #1; out_chk("mr.c3", 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
